// File: rtl/tdo_mux_secure_param.sv
// Registered TDO source multiplexer with a secure-channel lock FSM, a
// saturating violation counter and a reset-only freeze state.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_LOCKED   | secure channels read as 0; Shift-DR entries to them count
// S_UNLOCKED | PUF authentication succeeded; secure channels pass through
// S_FROZEN   | violation limit reached; stays locked until TRST_N
module tdo_mux_secure_param #(
  parameter int                         IR_W        = 4,
  parameter int                         NUM_DR      = 6,
  parameter int                         ST_W        = 4,
  parameter logic [ST_W-1:0]            ST_SHIFT_IR = 4'd11,
  parameter logic [ST_W-1:0]            ST_SHIFT_DR = 4'd4,
  parameter logic [ST_W-1:0]            ST_TLR      = 4'd15,
  parameter logic [NUM_DR*IR_W-1:0]     DR_CODES    = {4'h7, 4'h6, 4'h3, 4'h0, 4'h1, 4'hE},
  parameter logic [IR_W-1:0]            BYPASS_CODE = 4'hF,
  parameter logic [NUM_DR-1:0]          SECURE_MASK = 6'b110000,
  parameter int                         MAX_VIOL    = 3
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic [ST_W-1:0]   tap_state,
  input  logic [IR_W-1:0]   IR,
  input  logic              ir_tdo,
  input  logic [NUM_DR-1:0] dr_tdo,
  input  logic              bypass_tdo,
  input  logic              stdo,
  input  logic              unlock,
  input  logic              lock_req,
  output logic              TDO,
  output logic              TDO_EN,
  output logic              locked,
  output logic              frozen,
  output logic [7:0]        viol_cnt,
  output logic              viol_pulse
);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_FROZEN   = 2'd2
  } state_t;

  localparam logic [7:0] MAX_V = 8'(MAX_VIOL);

  state_t          r_state;
  logic [ST_W-1:0] r_prev_tap;
  logic            r_tdo;
  logic            r_tdo_en;
  logic [7:0]      r_viol_cnt;
  logic            r_viol_pulse;

  logic       w_shift_ir;
  logic       w_shift_dr;
  logic       w_hit;
  logic       w_dr_bit;
  logic       w_dr_sec;
  logic       w_sel;
  logic       w_sel_sec;
  logic       w_gated;
  logic       w_viol;
  logic [7:0] w_cnt_inc;
  logic       w_freeze;

  assign w_shift_ir = (tap_state == ST_SHIFT_IR);
  assign w_shift_dr = (tap_state == ST_SHIFT_DR);

  // Scan from the top down so the lowest matching channel is the last write.
  always_comb begin
    w_hit    = 1'b0;
    w_dr_bit = 1'b0;
    w_dr_sec = 1'b0;
    for (int k = NUM_DR - 1; k >= 0; k--) begin
      if (IR == DR_CODES[k*IR_W +: IR_W]) begin
        w_hit    = 1'b1;
        w_dr_bit = dr_tdo[k];
        w_dr_sec = SECURE_MASK[k];
      end
    end
  end

  always_comb begin
    w_sel     = stdo;
    w_sel_sec = 1'b0;
    if (w_shift_ir) begin
      w_sel = ir_tdo;
    end else if (w_shift_dr && w_hit) begin
      w_sel     = w_dr_bit;
      w_sel_sec = w_dr_sec;
    end else if (w_shift_dr && (IR == BYPASS_CODE)) begin
      w_sel = bypass_tdo;
    end
  end

  assign w_gated   = w_sel & ~(w_sel_sec && (r_state != S_UNLOCKED));
  assign w_viol    = w_shift_dr && (r_prev_tap != ST_SHIFT_DR) && w_sel_sec &&
                     (r_state != S_UNLOCKED);
  assign w_cnt_inc = (r_viol_cnt == 8'hFF) ? 8'hFF : r_viol_cnt + 8'd1;
  assign w_freeze  = w_viol && (w_cnt_inc >= MAX_V);

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_state      <= S_LOCKED;
      r_prev_tap   <= ST_TLR;
      r_tdo        <= 1'b0;
      r_tdo_en     <= 1'b0;
      r_viol_cnt   <= 8'd0;
      r_viol_pulse <= 1'b0;
    end else begin
      r_tdo        <= w_gated;
      r_tdo_en     <= w_shift_ir | w_shift_dr;
      r_prev_tap   <= tap_state;
      r_viol_pulse <= w_viol;
      if (w_viol) r_viol_cnt <= w_cnt_inc;
      case (r_state)
        S_LOCKED: begin
          if (w_freeze)                r_state <= S_FROZEN;
          else if (unlock && !lock_req) r_state <= S_UNLOCKED;
        end
        S_UNLOCKED: begin
          if (w_freeze)                          r_state <= S_FROZEN;
          else if (lock_req || tap_state == ST_TLR) r_state <= S_LOCKED;
        end
        S_FROZEN: r_state <= S_FROZEN;
        default:  r_state <= S_LOCKED;
      endcase
    end
  end

  assign TDO        = r_tdo;
  assign TDO_EN     = r_tdo_en;
  assign locked     = (r_state != S_UNLOCKED);
  assign frozen     = (r_state == S_FROZEN);
  assign viol_cnt   = r_viol_cnt;
  assign viol_pulse = r_viol_pulse;

endmodule

// File: tb/tb_tdo_mux_secure_param.sv
// Directed bench for tdo_mux_secure_param: default instance plus a
// MAX_VIOL=255 instance for counter saturation.
module tb_tdo_mux_secure_param;

  logic       tck = 1'b0;
  logic       trst_n;
  logic [3:0] tap_state;
  logic [3:0] ir;
  logic       ir_tdo;
  logic [5:0] dr_tdo;
  logic       bypass_tdo;
  logic       stdo;
  logic       unlock;
  logic       lock_req;

  logic       tdo, tdo_en, locked, frozen, viol_pulse;
  logic [7:0] viol_cnt;
  logic       tdo_b, tdo_en_b, locked_b, frozen_b, viol_pulse_b;
  logic [7:0] viol_cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  tdo_mux_secure_param u_dut (
    .TCK(tck), .TRST_N(trst_n), .tap_state(tap_state), .IR(ir),
    .ir_tdo(ir_tdo), .dr_tdo(dr_tdo), .bypass_tdo(bypass_tdo), .stdo(stdo),
    .unlock(unlock), .lock_req(lock_req),
    .TDO(tdo), .TDO_EN(tdo_en), .locked(locked), .frozen(frozen),
    .viol_cnt(viol_cnt), .viol_pulse(viol_pulse)
  );

  tdo_mux_secure_param #(.MAX_VIOL(255)) u_dut255 (
    .TCK(tck), .TRST_N(trst_n), .tap_state(tap_state), .IR(ir),
    .ir_tdo(ir_tdo), .dr_tdo(dr_tdo), .bypass_tdo(bypass_tdo), .stdo(stdo),
    .unlock(unlock), .lock_req(lock_req),
    .TDO(tdo_b), .TDO_EN(tdo_en_b), .locked(locked_b), .frozen(frozen_b),
    .viol_cnt(viol_cnt_b), .viol_pulse(viol_pulse_b)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic do_reset();
    trst_n     = 1'b0;
    tap_state  = 4'd5;
    ir         = 4'h0;
    ir_tdo     = 1'b0;
    dr_tdo     = 6'h00;
    bypass_tdo = 1'b0;
    stdo       = 1'b0;
    unlock     = 1'b0;
    lock_req   = 1'b0;
    #2;
    chk("rst_tdo", {7'd0, tdo}, 8'd0);
    chk("rst_tdo_en", {7'd0, tdo_en}, 8'd0);
    chk("rst_locked", {7'd0, locked}, 8'd1);
    chk("rst_frozen", {7'd0, frozen}, 8'd0);
    chk("rst_viol_cnt", viol_cnt, 8'd0);
    chk("rst_viol_pulse", {7'd0, viol_pulse}, 8'd0);
    #1;
    trst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Shift-IR passthrough
    tap_state = 4'd11; ir_tdo = 1'b1; step();
    chk("ir_tdo1", {7'd0, tdo}, 8'd1);
    chk("ir_en", {7'd0, tdo_en}, 8'd1);
    ir_tdo = 1'b0; step();
    chk("ir_tdo0", {7'd0, tdo}, 8'd0);
    ir_tdo = 1'b1; step();
    chk("ir_tdo1b", {7'd0, tdo}, 8'd1);
    chk("ir_locked", {7'd0, locked}, 8'd1);
    chk("ir_cnt", viol_cnt, 8'd0);

    // Locked access to secure channel (code 6)
    tap_state = 4'd5; step();
    ir = 4'h6; dr_tdo = 6'h3F; tap_state = 4'd4; step();
    chk("v1_tdo", {7'd0, tdo}, 8'd0);
    chk("v1_pulse", {7'd0, viol_pulse}, 8'd1);
    chk("v1_cnt", viol_cnt, 8'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("v1_hold_tdo", {7'd0, tdo}, 8'd0);
      chk("v1_hold_pulse", {7'd0, viol_pulse}, 8'd0);
    end
    chk("v1_hold_cnt", viol_cnt, 8'd1);
    tap_state = 4'd5; step();
    chk("v1_exit_pulse", {7'd0, viol_pulse}, 8'd0);
    tap_state = 4'd4; step();
    chk("v2_pulse", {7'd0, viol_pulse}, 8'd1);
    chk("v2_cnt", viol_cnt, 8'd2);
    // Non-secure channels while locked
    ir = 4'hE; dr_tdo = 6'b000001; step();
    chk("ch0_tdo", {7'd0, tdo}, 8'd1);
    ir = 4'h1; dr_tdo = 6'b000010; step();
    chk("ch1_tdo1", {7'd0, tdo}, 8'd1);
    dr_tdo = 6'b111101; step();
    chk("ch1_tdo0", {7'd0, tdo}, 8'd0);
    chk("ns_cnt", viol_cnt, 8'd2);
    tap_state = 4'd5; step();

    // Unlock, secure read, relock via TLR
    unlock = 1'b1; step();
    chk("unl_locked", {7'd0, locked}, 8'd0);
    unlock = 1'b0;
    ir = 4'h7; dr_tdo = 6'h3F; tap_state = 4'd4; step();
    chk("unl_tdo", {7'd0, tdo}, 8'd1);
    chk("unl_pulse", {7'd0, viol_pulse}, 8'd0);
    chk("unl_cnt", viol_cnt, 8'd2);
    tap_state = 4'd15; step();
    chk("tlr_locked", {7'd0, locked}, 8'd1);
    tap_state = 4'd5; step();
    tap_state = 4'd4; step();
    chk("relock_tdo", {7'd0, tdo}, 8'd0);
    chk("relock_cnt", viol_cnt, 8'd3);
    chk("relock_frozen", {7'd0, frozen}, 8'd1);
    tap_state = 4'd5; step();

    // Freeze after three violations
    do_reset();
    ir = 4'h6; dr_tdo = 6'h3F;
    for (int i = 1; i <= 3; i++) begin
      tap_state = 4'd4; step();
      chk("frz_cnt", viol_cnt, 8'(i));
      chk("frz_frozen", {7'd0, frozen}, (i == 3) ? 8'd1 : 8'd0);
      tap_state = 4'd5; step();
    end
    unlock = 1'b1; step();
    unlock = 1'b0;
    chk("frz_unl_frozen", {7'd0, frozen}, 8'd1);
    chk("frz_unl_locked", {7'd0, locked}, 8'd1);
    tap_state = 4'd4; step();
    chk("frz_tdo", {7'd0, tdo}, 8'd0);
    chk("frz_cnt4", viol_cnt, 8'd4);
    tap_state = 4'd5; step();
    do_reset();

    // Simultaneous unlock/lock_req, bypass, default path
    unlock = 1'b1; lock_req = 1'b1; step();
    chk("both_locked", {7'd0, locked}, 8'd1);
    unlock = 1'b0; lock_req = 1'b0;
    ir = 4'hF; tap_state = 4'd4; bypass_tdo = 1'b1; step();
    chk("byp_tdo1", {7'd0, tdo}, 8'd1);
    chk("byp_en", {7'd0, tdo_en}, 8'd1);
    bypass_tdo = 1'b0; step();
    chk("byp_tdo0", {7'd0, tdo}, 8'd0);
    ir = 4'h9; stdo = 1'b1; step();
    chk("stdo_dr_tdo", {7'd0, tdo}, 8'd1);
    chk("stdo_dr_en", {7'd0, tdo_en}, 8'd1);
    stdo = 1'b0; step();
    chk("stdo_dr_tdo0", {7'd0, tdo}, 8'd0);
    tap_state = 4'd5; stdo = 1'b1; step();
    chk("stdo_idle_tdo", {7'd0, tdo}, 8'd1);
    chk("stdo_idle_en", {7'd0, tdo_en}, 8'd0);
    chk("path_cnt", viol_cnt, 8'd0);

    // Violation and unlock in the same cycle
    stdo = 1'b0; ir = 4'h6; dr_tdo = 6'h3F; tap_state = 4'd4; unlock = 1'b1; step();
    chk("vu_cnt", viol_cnt, 8'd1);
    chk("vu_pulse", {7'd0, viol_pulse}, 8'd1);
    chk("vu_locked", {7'd0, locked}, 8'd0);
    chk("vu_tdo", {7'd0, tdo}, 8'd0);
    unlock = 1'b0; step();
    chk("vu_tdo_after", {7'd0, tdo}, 8'd1);
    chk("vu_pulse_after", {7'd0, viol_pulse}, 8'd0);
    tap_state = 4'd5; step();

    // Saturation with MAX_VIOL=255
    do_reset();
    ir = 4'h6; dr_tdo = 6'h3F;
    for (int i = 0; i < 300; i++) begin
      tap_state = 4'd4; step();
      chk("sat_pulse", {7'd0, viol_pulse_b}, 8'd1);
      if (i == 253) chk("sat_pre_frozen", {7'd0, frozen_b}, 8'd0);
      if (i == 254) chk("sat_frozen_at", {7'd0, frozen_b}, 8'd1);
      tap_state = 4'd5; step();
    end
    chk("sat_cnt", viol_cnt_b, 8'd255);
    chk("sat_frozen", {7'd0, frozen_b}, 8'd1);
    chk("sat_cnt_small", viol_cnt, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
